// File: rtl/argmax_pkg.sv
// Shared types and helpers for the argmax score sequencer.
// Scores are two's complement; index width covers up to 32 classes.
package argmax_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 5;
    localparam int LANES  = 4;

    localparam logic [DATA_W-1:0] SCORE_MIN = 8'h80;

    typedef logic [DATA_W-1:0] score_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HOLD
    } state_t;

    // Signed a > b: flipping the sign bit maps two's complement onto
    // an order-preserving unsigned range.
    function automatic logic sgt(input score_t a, input score_t b);
        return {~a[DATA_W-1], a[DATA_W-2:0]} > {~b[DATA_W-1], b[DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/argmax4_stage.sv
// Registered 4-lane masked signed maximum.
// Lanes are scanned low to high with strict-greater replace, so ties go low.
module argmax4_stage
    import argmax_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES*DATA_W-1:0] scores,
    input  idx_t                    base,
    input  logic [LANES-1:0]        mask,
    input  logic                    in_valid,
    output score_t                  best_score,
    output idx_t                    best_index,
    output logic                    out_valid
);

    score_t c_score;
    idx_t   c_index;
    logic   c_found;

    // Pick the best valid lane of the current group.
    always_comb begin
        c_score = SCORE_MIN;
        c_index = base;
        c_found = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i] &&
                (!c_found || sgt(scores[i*DATA_W +: DATA_W], c_score))) begin
                c_score = scores[i*DATA_W +: DATA_W];
                c_index = base + idx_t'(i);
                c_found = 1'b1;
            end
        end
    end

    // Register the group winner; a group with no valid lane is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            best_score <= SCORE_MIN;
            best_index <= '0;
        end else begin
            out_valid <= in_valid && c_found;
            if (in_valid) begin
                best_score <= c_score;
                best_index <= c_index;
            end
        end
    end

endmodule

// File: rtl/argmax_sequencer.sv
// Walks the score buffer one 4-lane group per cycle and keeps a running
// signed maximum; the winner is offered on a valid/ready result port.
module argmax_sequencer
    import argmax_pkg::*;
#(
    parameter int NUM_CLASSES = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    rd_en,
    output logic [IDX_W-3:0]        rd_addr,
    input  logic [LANES*DATA_W-1:0] rd_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output idx_t                    res_index,
    output score_t                  res_score
);

    localparam int AW = IDX_W - 2;
    localparam int G  = (NUM_CLASSES + LANES - 1) / LANES;
    localparam logic [AW-1:0] LAST = AW'(G - 1);

    state_t          state, state_n;
    logic            drain_cnt;
    logic            clr_acc, load_res;
    logic            rd_pend;
    logic [AW-1:0]   addr_q;
    logic [LANES-1:0] mask;

    score_t g_score;
    idx_t   g_index;
    logic   g_valid;

    score_t acc_score;
    idx_t   acc_index;
    logic   acc_valid;
    logic   take;
    score_t m_score;
    idx_t   m_index;

    // Mask lanes beyond the last real class in the returning group.
    always_comb begin
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = (int'(addr_q) * LANES + i) < NUM_CLASSES;
        end
    end

    argmax4_stage u_stage (
        .clk        (clk),
        .reset      (reset),
        .scores     (rd_data),
        .base       ({addr_q, 2'b00}),
        .mask       (mask),
        .in_valid   (rd_pend),
        .best_score (g_score),
        .best_index (g_index),
        .out_valid  (g_valid)
    );

    // Merge the group winner; earlier groups keep ties.
    always_comb begin
        take    = g_valid && (!acc_valid || sgt(g_score, acc_score));
        m_score = take ? g_score : acc_score;
        m_index = take ? g_index : acc_index;
    end

    // Next state and control strobes.
    always_comb begin
        state_n   = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        clr_acc   = 1'b0;
        load_res  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    clr_acc = 1'b1;
                end
            end
            FETCH: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (rd_addr == LAST) state_n = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) begin
                    state_n  = HOLD;
                    load_res = 1'b1;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, address counter, drain timer and read-return tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_addr   <= '0;
            drain_cnt <= 1'b0;
            rd_pend   <= 1'b0;
            addr_q    <= '0;
        end else begin
            state     <= state_n;
            rd_pend   <= rd_en;
            addr_q    <= rd_addr;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (state == FETCH) begin
                rd_addr <= (rd_addr == LAST) ? '0 : rd_addr + AW'(1);
            end
        end
    end

    // Running maximum, cleared when a search is accepted.
    always_ff @(posedge clk) begin
        if (reset || clr_acc) begin
            acc_valid <= 1'b0;
            acc_score <= SCORE_MIN;
            acc_index <= '0;
        end else if (take) begin
            acc_valid <= 1'b1;
            acc_score <= g_score;
            acc_index <= g_index;
        end
    end

    // Result registers update only as the result is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_index <= '0;
            res_score <= SCORE_MIN;
        end else if (load_res) begin
            res_index <= m_index;
            res_score <= m_score;
        end
    end

endmodule

// File: tb/tb_argmax_sequencer.sv
// Bench for argmax_sequencer: cycle-level reference model plus directed runs.
// A second instance exercises a padded 22-class build.
module tb_argmax_sequencer;
    import argmax_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        res_ready = 1'b0;
    logic        busy, rd_en, res_valid;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  res_index;
    logic [7:0]  res_score;

    logic        start22 = 1'b0;
    logic        ready22 = 1'b0;
    logic        busy22, rd_en22, valid22;
    logic [2:0]  rd_addr22;
    logic [31:0] rd_data22;
    logic [4:0]  index22;
    logic [7:0]  score22;

    logic [7:0] scores [32];
    int pass_cnt = 0;
    int total = 0;
    bit chk_en = 0;

    argmax_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_index(res_index), .res_score(res_score)
    );

    argmax_sequencer #(.NUM_CLASSES(22)) dut22 (
        .clk(clk), .reset(reset), .start(start22), .busy(busy22),
        .rd_en(rd_en22), .rd_addr(rd_addr22), .rd_data(rd_data22),
        .res_valid(valid22), .res_ready(ready22),
        .res_index(index22), .res_score(score22)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [31:0] grp(input int g);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = scores[(4*g + i) % 32];
        return r;
    endfunction

    // Lowest index of the signed maximum over the first n classes.
    function automatic int ref_argmax(input int n);
        int b = 0;
        for (int i = 1; i < n; i++)
            if ($signed(scores[i]) > $signed(scores[b])) b = i;
        return b;
    endfunction

    // Score buffer: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        rd_data   <= (rd_en === 1'b1)   ? grp(int'(rd_addr))   : $urandom;
        rd_data22 <= (rd_en22 === 1'b1) ? grp(int'(rd_addr22)) : $urandom;
    end

    // Reference model for the 24-class instance (G = 6).
    int         m_t = -1;
    bit         m_hold = 0;
    logic [4:0] m_idx = 5'd0;
    logic [7:0] m_score = 8'h80;

    always @(posedge clk) begin
        if (reset) begin
            m_t <= -1; m_hold <= 0; m_idx <= 5'd0; m_score <= 8'h80;
        end else if (m_hold) begin
            if (res_ready) m_hold <= 0;
        end else if (m_t < 0) begin
            if (start) m_t <= 1;
        end else if (m_t + 1 == 9) begin
            m_t <= -1;
            m_hold <= 1;
            m_idx <= 5'(ref_argmax(24));
            m_score <= scores[ref_argmax(24)];
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_t >= 1));
            chk("rd_en", 32'(rd_en), 32'(m_t >= 1 && m_t <= 6));
            if (m_t >= 1 && m_t <= 6) chk("rd_addr", 32'(rd_addr), 32'(m_t - 1));
            chk("res_valid", 32'(res_valid), 32'(m_hold));
            chk("res_index", 32'(res_index), 32'(m_idx));
            chk("res_score", 32'(res_score), 32'(m_score));
        end
    end

    task automatic run(input string name, input logic [4:0] eidx,
                       input logic [7:0] escore, input bit consume);
        int lat = -1;
        @(posedge clk); #1 start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (res_valid) begin lat = i; break; end
        end
        start = 1'b0;
        chk({name, " latency"}, lat, 9);
        chk({name, " index"}, 32'(res_index), 32'(eidx));
        chk({name, " score"}, 32'(res_score), 32'(escore));
        if (consume) begin
            @(posedge clk); #1 res_ready = 1'b1;
            @(posedge clk); #1 res_ready = 1'b0;
            @(negedge clk);
            chk({name, " released"}, 32'(res_valid), 0);
        end
    endtask

    initial begin
        int n;
        int lat;
        for (int i = 0; i < 32; i++) scores[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1 chk_en = 1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst rd_en", 32'(rd_en), 0);
        chk("rst rd_addr", 32'(rd_addr), 0);
        chk("rst res_valid", 32'(res_valid), 0);
        chk("rst res_index", 32'(res_index), 0);
        chk("rst res_score", 32'(res_score), 32'h80);

        run("ramp", 5'd23, 8'h17, 1);

        for (int i = 0; i < 32; i++) scores[i] = 8'h00;
        scores[7] = 8'h7F; scores[19] = 8'h7F;
        run("tie", 5'd7, 8'h7F, 1);

        for (int i = 0; i < 32; i++) scores[i] = 8'h80;
        run("allmin", 5'd0, 8'h80, 1);

        for (int i = 0; i < 32; i++) scores[i] = 8'hF0;
        scores[12] = 8'hFF;
        res_ready = 1'b1;
        run("neg", 5'd12, 8'hFF, 0);
        @(posedge clk); #1 res_ready = 1'b0;

        for (int i = 0; i < 32; i++) scores[i] = 8'h05;
        scores[0] = 8'h06;
        run("hold", 5'd0, 8'h06, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 start = (i == 5);
        end
        start = 1'b0;
        @(negedge clk);
        chk("hold valid", 32'(res_valid), 1);
        chk("hold index", 32'(res_index), 0);
        @(posedge clk); #1 res_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("hold+start busy", 32'(busy), 0);
        chk("hold+start valid", 32'(res_valid), 0);
        for (int i = 0; i < 32; i++) scores[i] = 8'(i);
        run("rerun", 5'd23, 8'h17, 1);

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 0);
        chk("abort rd_en", 32'(rd_en), 0);
        chk("abort valid", 32'(res_valid), 0);
        repeat (15) @(posedge clk);
        for (int i = 0; i < 32; i++) scores[i] = 8'h00;
        scores[9] = 8'h7F;
        run("after reset", 5'd9, 8'h7F, 1);

        for (int i = 0; i < 32; i++) scores[i] = 8'h00;
        scores[5] = 8'h10; scores[22] = 8'h7F; scores[23] = 8'h7F;
        n = 0; lat = -1;
        @(posedge clk); #1 start22 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 1) start22 = 1'b0;
            if (rd_en22) n++;
            if (valid22) begin lat = i; break; end
        end
        start22 = 1'b0;
        chk("pad reads", n, 6);
        chk("pad latency", lat, 9);
        chk("pad index", 32'(index22), 5);
        chk("pad score", 32'(score22), 32'h10);
        @(posedge clk); #1 ready22 = 1'b1;
        @(posedge clk); #1 ready22 = 1'b0;
        @(negedge clk);
        chk("pad released", 32'(valid22), 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
